cam_capture: RTL and testbench

- Parametrised OV7670 capture front-end in the pclk domain.
- Decodes vsync/href framing and assembles the 2-byte-per-pixel camera stream into 8-bit pixels.
- Supports run-time format modes (RGB332, grayscale, YUV Y-only) and integer decimation.
- Writes pixels sequentially into the dual-port frame buffer; reports frame completion and framing errors to the control logic.

---
 rtl/cam_pkg.sv | 25 ++
 rtl/cam_capture_if.sv | 22 ++
 rtl/cam_px_conv.sv | 27 ++
 rtl/cam_capture.sv | 194 +++++++++++++++++++
 tb/tb_cam_capture.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared encodings for the OV7670 capture front-end: pixel format modes,
// framing FSM states and the frame-size helper.
package cam_pkg;

   // Pixel format selected at run time; 2'b11 behaves like RGB332.
   typedef enum logic [1:0] {
      MODE_RGB332     = 2'b00,
      MODE_GRAY       = 2'b01,
      MODE_Y          = 2'b10,
      MODE_RGB332_ALT = 2'b11
   } cam_mode_e;

   // Framing FSM: IDLE discards the partial frame seen after reset.
   typedef enum logic [1:0] {
      ST_IDLE       = 2'b00,
      ST_WAIT_START = 2'b01,
      ST_CAPTURE    = 2'b10
   } cam_state_e;

   // Number of stored pixels in one frame.
   function automatic int frame_size(input int w, input int h);
      return w * h;
   endfunction

endpackage

// File: rtl/cam_capture_if.sv
// Camera byte bus plus frame-buffer write port. The master side is the
// capture block (consumes camera bytes, drives the memory write).
interface cam_capture_if #(
   parameter int AW = 15
);
   logic          vsync;
   logic          href;
   logic [7:0]    px_data;
   logic [AW-1:0] mem_px_addr;
   logic [7:0]    mem_px_data;
   logic          px_wr;

   modport master (
      input  vsync, href, px_data,
      output mem_px_addr, mem_px_data, px_wr
   );

   modport slave (
      output vsync, href, px_data,
      input  mem_px_addr, mem_px_data, px_wr
   );
endinterface

// File: rtl/cam_px_conv.sv
// Combinational pixel converter: turns the two camera bytes of one pixel
// into an 8-bit stored pixel according to the latched format mode.
module cam_px_conv
   import cam_pkg::*;
(
   input  logic [7:0] hi,
   input  logic [7:0] lo,
   input  cam_mode_e  mode,
   output logic [7:0] px
);

   logic [7:0] gray;

   // Gray is 2*R5 + 2*G6 + 2*B5, which peaks at 250 and so fits in 8 bits.
   always_comb begin
      gray = {2'b00, hi[7:3], 1'b0}
           + {1'b0, hi[2:0], lo[7:5], 1'b0}
           + {2'b00, lo[4:0], 1'b0};
      px   = {hi[7:5], hi[2:0], lo[4:3]};
      case (mode)
         MODE_GRAY: px = gray;
         MODE_Y:    px = lo;
         default:   px = {hi[7:5], hi[2:0], lo[4:3]};
      endcase
   end

endmodule

// File: rtl/cam_capture.sv
// OV7670 capture front-end in the pclk domain. Decodes vsync/href framing,
// pairs camera bytes into pixels, decimates and writes pixels sequentially
// into the frame buffer. Define CAM_TEST_PATTERN_EN to add the test_en input
// that replaces camera data with a col+row pattern.
module cam_capture
   import cam_pkg::*;
#(
   parameter int AW    = 15,
   parameter int IMG_W = 160,
   parameter int IMG_H = 120,
   parameter int DEC   = 1
) (
   input  logic              pclk,
   input  logic              rst,
   cam_capture_if.master     bus,
   input  logic [1:0]        mode,
`ifdef CAM_TEST_PATTERN_EN
   input  logic              test_en,
`endif
   output logic              frame_done,
   output logic              busy,
   output logic              err
);

   localparam int            FS        = frame_size(IMG_W, IMG_H);
   localparam logic [AW-1:0] LAST_ADDR = AW'(FS - 1);
   localparam logic [15:0]   DMASK     = 16'(DEC - 1);

   cam_state_e    state_q, state_d;
   cam_mode_e     mode_q, mode_d;
   logic          vsync_q;
   logic          href_q;
   logic          phase_q, phase_d;
   logic [7:0]    hi_q, hi_d;
   logic [15:0]   x_q, x_d;
   logic [15:0]   y_q, y_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          full_q, full_d;
   logic          err_q, err_d;
   logic          frame_done_q, frame_done_d;
   logic          px_wr_q, px_wr_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic [7:0]    conv_px;
   logic [7:0]    px_value;
   logic          vs_rise, vs_fall, keep_px;

`ifdef CAM_TEST_PATTERN_EN
   localparam int DSH = $clog2(DEC);
   logic          test_en_q, test_en_d;
   logic [15:0]   col, row;
`endif

   cam_px_conv u_conv (
      .hi   (hi_q),
      .lo   (bus.px_data),
      .mode (mode_q),
      .px   (conv_px)
   );

   assign vs_rise = bus.vsync & ~vsync_q;
   assign vs_fall = ~bus.vsync & vsync_q;
   assign keep_px = ((x_q & DMASK) == 16'd0) && ((y_q & DMASK) == 16'd0);

`ifdef CAM_TEST_PATTERN_EN
   // Pattern uses stored (post-decimation) coordinates, wrapping at 256.
   always_comb begin
      col      = x_q >> DSH;
      row      = y_q >> DSH;
      px_value = test_en_q ? (col[7:0] + row[7:0]) : conv_px;
   end
`else
   assign px_value = conv_px;
`endif

   // Framing FSM plus byte pairing, counters and write-register next state.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      phase_d      = 1'b0;
      hi_d         = hi_q;
      x_d          = x_q;
      y_d          = y_q;
      addr_d       = addr_q;
      full_d       = full_q;
      err_d        = err_q;
      frame_done_d = 1'b0;
      px_wr_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
`ifdef CAM_TEST_PATTERN_EN
      test_en_d    = test_en_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (vs_rise) state_d = ST_WAIT_START;
         end
         ST_WAIT_START: begin
            if (vs_fall) begin
               state_d = ST_CAPTURE;
               mode_d  = cam_mode_e'(mode);
               addr_d  = '0;
               full_d  = 1'b0;
               x_d     = '0;
               y_d     = '0;
               err_d   = 1'b0;
`ifdef CAM_TEST_PATTERN_EN
               test_en_d = test_en;
`endif
            end
         end
         ST_CAPTURE: begin
            if (vs_rise) begin
               state_d      = ST_WAIT_START;
               frame_done_d = 1'b1;
            end else if (bus.href) begin
               phase_d = ~phase_q;
               if (!phase_q) begin
                  hi_d = bus.px_data;
               end else begin
                  x_d = x_q + 16'd1;
                  if (keep_px) begin
                     if (full_q) begin
                        err_d = 1'b1;
                     end else begin
                        px_wr_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = px_value;
                        if (addr_q == LAST_ADDR) full_d = 1'b1;
                        else                     addr_d = addr_q + 1'b1;
                     end
                  end
               end
            end else if (href_q) begin
               x_d = '0;
               y_d = y_q + 16'd1;
               if (phase_q) err_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         mode_q       <= MODE_RGB332;
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         phase_q      <= 1'b0;
         hi_q         <= '0;
         x_q          <= '0;
         y_q          <= '0;
         addr_q       <= '0;
         full_q       <= 1'b0;
         err_q        <= 1'b0;
         frame_done_q <= 1'b0;
         px_wr_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
`ifdef CAM_TEST_PATTERN_EN
         test_en_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         vsync_q      <= bus.vsync;
         href_q       <= bus.href;
         phase_q      <= phase_d;
         hi_q         <= hi_d;
         x_q          <= x_d;
         y_q          <= y_d;
         addr_q       <= addr_d;
         full_q       <= full_d;
         err_q        <= err_d;
         frame_done_q <= frame_done_d;
         px_wr_q      <= px_wr_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
`ifdef CAM_TEST_PATTERN_EN
         test_en_q    <= test_en_d;
`endif
      end
   end

   assign bus.mem_px_addr = wr_addr_q;
   assign bus.mem_px_data = wr_data_q;
   assign bus.px_wr       = px_wr_q;
   assign frame_done      = frame_done_q;
   assign busy            = (state_q == ST_CAPTURE);
   assign err             = err_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture. dut_a is 4x2 with no decimation, dut_b is
// 2x1 with DEC=2; both see the same camera stream, mode and reset.
module tb_cam_capture;

   logic       pclk = 1'b0;
   logic       rst = 1'b1;
   logic       vsync = 1'b0;
   logic       href = 1'b0;
   logic [7:0] px_data = 8'h00;
   logic [1:0] mode = 2'b00;

   logic frame_done_a, busy_a, err_a;
   logic frame_done_b, busy_b, err_b;

   int vectors = 0;
   int miscompares = 0;

   logic [2:0] qa_addr[$];
   logic [7:0] qa_data[$];
   logic [1:0] qb_addr[$];
   logic [7:0] qb_data[$];
   int         fd_a = 0;

   cam_capture_if #(.AW(3)) bus_a ();
   cam_capture_if #(.AW(2)) bus_b ();

   assign bus_a.vsync   = vsync;
   assign bus_a.href    = href;
   assign bus_a.px_data = px_data;
   assign bus_b.vsync   = vsync;
   assign bus_b.href    = href;
   assign bus_b.px_data = px_data;

   cam_capture #(.AW(3), .IMG_W(4), .IMG_H(2), .DEC(1)) dut_a (
      .pclk       (pclk),
      .rst        (rst),
      .bus        (bus_a),
      .mode       (mode),
      .frame_done (frame_done_a),
      .busy       (busy_a),
      .err        (err_a)
   );

   cam_capture #(.AW(2), .IMG_W(2), .IMG_H(1), .DEC(2)) dut_b (
      .pclk       (pclk),
      .rst        (rst),
      .bus        (bus_b),
      .mode       (mode),
      .frame_done (frame_done_b),
      .busy       (busy_b),
      .err        (err_b)
   );

   always #5 pclk = ~pclk;

   // Record every write and frame_done pulse, sampled on the falling edge.
   always @(negedge pclk) begin
      if (bus_a.px_wr === 1'b1) begin
         qa_addr.push_back(bus_a.mem_px_addr);
         qa_data.push_back(bus_a.mem_px_data);
      end
      if (bus_b.px_wr === 1'b1) begin
         qb_addr.push_back(bus_b.mem_px_addr);
         qb_data.push_back(bus_b.mem_px_data);
      end
      if (frame_done_a === 1'b1) fd_a++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic clear_logs();
      qa_addr.delete();
      qa_data.delete();
      qb_addr.delete();
      qb_data.delete();
      fd_a = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      px_data = b;
      href    = 1'b1;
      tick(1);
   endtask

   task automatic send_px(input logic [7:0] hi, input logic [7:0] lo);
      send_byte(hi);
      send_byte(lo);
   endtask

   task automatic end_line();
      href = 1'b0;
      tick(2);
   endtask

   task automatic start_frame();
      href  = 1'b0;
      vsync = 1'b1;
      tick(3);
      vsync = 1'b0;
      tick(3);
   endtask

   task automatic end_frame();
      href  = 1'b0;
      vsync = 1'b1;
      tick(3);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
      vectors++;
      if ({bus_a.px_wr, frame_done_a, busy_a, err_a} !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL reset_flags got %b want 0000", {bus_a.px_wr, frame_done_a, busy_a, err_a});
      end
      vectors++;
      if ({bus_a.mem_px_addr, bus_a.mem_px_data} !== 11'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_bus got addr=%0d data=%h want 0/00", bus_a.mem_px_addr, bus_a.mem_px_data);
      end
   endtask

   task automatic test_rgb332();
      mode = 2'b00;
      start_frame();
      clear_logs();
      vectors++;
      if (busy_a !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL rgb_busy got %b want 1", busy_a);
      end
      send_byte(8'hF8);
      vectors++;
      if (bus_a.px_wr !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL latency_early got px_wr=%b want 0", bus_a.px_wr);
      end
      send_byte(8'h1F);
      vectors++;
      if ({bus_a.px_wr, bus_a.mem_px_addr, bus_a.mem_px_data} !== {1'b1, 3'd0, 8'hE3}) begin
         miscompares++;
         $display("[TB] FAIL latency_first got wr=%b addr=%0d data=%h want 1/0/e3",
                  bus_a.px_wr, bus_a.mem_px_addr, bus_a.mem_px_data);
      end
      for (int i = 1; i < 4; i++) send_px(8'hF8, 8'h1F);
      end_line();
      for (int i = 0; i < 4; i++) send_px(8'hF8, 8'h1F);
      end_line();
      end_frame();
      vectors++;
      if (qa_addr.size() !== 8) begin
         miscompares++;
         $display("[TB] FAIL rgb_count got %0d want 8", qa_addr.size());
      end
      for (int i = 0; i < 8 && i < qa_addr.size(); i++) begin
         vectors++;
         if (qa_addr[i] !== 3'(i) || qa_data[i] !== 8'hE3) begin
            miscompares++;
            $display("[TB] FAIL rgb_write[%0d] got addr=%0d data=%h want %0d/e3", i, qa_addr[i], qa_data[i], i);
         end
      end
      vectors++;
      if (fd_a !== 1 || err_a !== 1'b0 || busy_a !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL rgb_end got frame_done=%0d err=%b busy=%b want 1/0/0", fd_a, err_a, busy_a);
      end
   endtask

   task automatic test_gray();
      mode = 2'b01;
      start_frame();
      clear_logs();
      mode = 2'b10;
      send_px(8'hFF, 8'hFF);
      send_px(8'h00, 8'h00);
      end_line();
      end_frame();
      vectors++;
      if (qa_data.size() !== 2) begin
         miscompares++;
         $display("[TB] FAIL gray_count got %0d want 2", qa_data.size());
      end else begin
         vectors++;
         if (qa_data[0] !== 8'd250 || qa_data[1] !== 8'd0 || qa_addr[1] !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL gray_data got %0d,%0d addr1=%0d want 250,0 addr1=1", qa_data[0], qa_data[1], qa_addr[1]);
         end
      end
   endtask

   task automatic test_mode_y();
      mode = 2'b10;
      start_frame();
      clear_logs();
      send_px(8'h55, 8'h9C);
      end_line();
      end_frame();
      vectors++;
      if (qa_data.size() !== 1 || qa_data[0] !== 8'h9C) begin
         miscompares++;
         $display("[TB] FAIL y_data got n=%0d data=%h want 1/9c", qa_data.size(), qa_data[0]);
      end
   endtask

   task automatic test_decimation();
      mode = 2'b10;
      start_frame();
      clear_logs();
      for (int y = 0; y < 4; y++) begin
         for (int x = 0; x < 4; x++) send_px(8'h80, 8'((y << 4) | x));
         end_line();
      end
      vectors++;
      if (qb_data.size() !== 2) begin
         miscompares++;
         $display("[TB] FAIL dec_count got %0d want 2", qb_data.size());
      end else begin
         vectors++;
         if (qb_data[0] !== 8'h00 || qb_data[1] !== 8'h02 || qb_addr[0] !== 2'd0 || qb_addr[1] !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL dec_data got %h@%0d %h@%0d want 00@0 02@1", qb_data[0], qb_addr[0], qb_data[1], qb_addr[1]);
         end
      end
      vectors++;
      if (err_b !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL dec_overflow_err got %b want 1", err_b);
      end
      end_frame();
   endtask

   task automatic test_odd_line();
      mode = 2'b00;
      start_frame();
      clear_logs();
      for (int i = 0; i < 4; i++) send_px(8'hF8, 8'h1F);
      send_byte(8'hF8);
      vectors++;
      if (err_a !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL odd_err_early got %b want 0", err_a);
      end
      end_line();
      vectors++;
      if (err_a !== 1'b1 || qa_addr.size() !== 4) begin
         miscompares++;
         $display("[TB] FAIL odd_err got err=%b writes=%0d want 1/4", err_a, qa_addr.size());
      end
      end_frame();
      start_frame();
      vectors++;
      if (err_a !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL odd_err_clear got %b want 0", err_a);
      end
      end_frame();
   endtask

   task automatic test_overflow();
      mode = 2'b10;
      start_frame();
      clear_logs();
      for (int y = 0; y < 3; y++) begin
         if (y == 2) begin
            vectors++;
            if (err_a !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL ovf_err_early got %b want 0", err_a);
            end
         end
         for (int x = 0; x < 4; x++) send_px(8'h00, 8'((y << 4) | x));
         end_line();
      end
      vectors++;
      if (qa_addr.size() !== 8) begin
         miscompares++;
         $display("[TB] FAIL ovf_count got %0d want 8", qa_addr.size());
      end
      for (int i = 0; i < 8 && i < qa_data.size(); i++) begin
         vectors++;
         if (qa_data[i] !== 8'(((i / 4) << 4) | (i % 4))) begin
            miscompares++;
            $display("[TB] FAIL ovf_data[%0d] got %h want %h", i, qa_data[i], 8'(((i / 4) << 4) | (i % 4)));
         end
      end
      vectors++;
      if (err_a !== 1'b1 || bus_a.mem_px_addr !== 3'd7 || bus_a.mem_px_data !== 8'h13) begin
         miscompares++;
         $display("[TB] FAIL ovf_hold got err=%b addr=%0d data=%h want 1/7/13", err_a, bus_a.mem_px_addr, bus_a.mem_px_data);
      end
      end_frame();
   endtask

   task automatic test_reset_mid();
      mode = 2'b00;
      start_frame();
      clear_logs();
      send_px(8'hF8, 8'h1F);
      send_px(8'hF8, 8'h1F);
      send_byte(8'hF8);
      rst  = 1'b1;
      href = 1'b0;
      tick(1);
      rst = 1'b0;
      vectors++;
      if ({bus_a.px_wr, busy_a, err_a, frame_done_a, bus_a.mem_px_addr, bus_a.mem_px_data} !== 15'd0) begin
         miscompares++;
         $display("[TB] FAIL rstmid_outputs got wr=%b busy=%b err=%b fd=%b addr=%0d data=%h want all 0",
                  bus_a.px_wr, busy_a, err_a, frame_done_a, bus_a.mem_px_addr, bus_a.mem_px_data);
      end
      clear_logs();
      for (int i = 0; i < 4; i++) send_px(8'hF8, 8'h1F);
      end_line();
      vectors++;
      if (qa_addr.size() !== 0) begin
         miscompares++;
         $display("[TB] FAIL rstmid_no_write got %0d writes want 0", qa_addr.size());
      end
      start_frame();
      send_px(8'hF8, 8'h1F);
      end_line();
      vectors++;
      if (qa_addr.size() !== 1 || qa_addr[0] !== 3'd0) begin
         miscompares++;
         $display("[TB] FAIL rstmid_restart got n=%0d addr=%0d want 1/0", qa_addr.size(), qa_addr[0]);
      end
      end_frame();
   endtask

   initial begin
      test_reset();
      test_rgb332();
      test_gray();
      test_mode_y();
      test_decimation();
      test_odd_line();
      test_overflow();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
